// File: rtl/rsa_control.sv
// RSA control: derives n, phi and d = 65537^-1 mod phi from p/q, then runs
// left-to-right square-and-multiply modular exponentiation with the e or d exponent.
module rsa_control #(
  parameter int unsigned WIDTH = 128
) (
  input  logic               clk,
  input  logic               reset_inverter,
  input  logic               reset_mod_exp,
  input  logic [WIDTH-1:0]   p,
  input  logic [WIDTH-1:0]   q,
  input  logic               encrypt_decrypt,
  input  logic [2*WIDTH-1:0] msg_in,
  output logic               inverter_finish,
  output logic [2*WIDTH-1:0] msg_out,
  output logic               mod_exp_finish
);

  localparam int unsigned XW = 2 * WIDTH;
  localparam int unsigned MW = XW + 2;
  localparam int unsigned CW = $clog2(XW);
  localparam logic [XW-1:0] E_PUB = XW'(65537);

  localparam logic [2:0] INV_LOAD  = 3'd0;
  localparam logic [2:0] INV_CHECK = 3'd1;
  localparam logic [2:0] INV_DIV   = 3'd2;
  localparam logic [2:0] INV_SWAP  = 3'd3;
  localparam logic [2:0] INV_FIN   = 3'd4;
  localparam logic [2:0] INV_DONE  = 3'd5;

  localparam logic [2:0] ME_LOAD   = 3'd0;
  localparam logic [2:0] ME_REDUCE = 3'd1;
  localparam logic [2:0] ME_SQUARE = 3'd2;
  localparam logic [2:0] ME_MULT   = 3'd3;
  localparam logic [2:0] ME_NEXT   = 3'd4;
  localparam logic [2:0] ME_DONE   = 3'd5;

  logic [2:0]           inv_state_q, inv_state_d;
  logic                 inv_done_q, inv_done_d;
  logic [XW-1:0]        n_q, n_d, phi_q, phi_d, a_q, a_d, b_q, b_d, d_q, d_d;
  logic signed [MW-1:0] x_q, x_d, y_q, y_d;
  logic [CW-1:0]        k_q, k_d;

  logic [2:0]    me_state_q, me_state_d;
  logic          me_done_q, me_done_d;
  logic [XW-1:0] msg_out_q, msg_out_d;
  logic [XW-1:0] mn_q, mn_d, exp_q, exp_d, base_q, base_d, res_q, res_d;
  logic [XW-1:0] acc_q, acc_d, mb_q, mb_d, ma_q, ma_d;
  logic [CW-1:0] cnt_q, cnt_d, bit_q, bit_d;
  logic [MW-1:0] dbl, dbl_r, sum, step;
  logic [XW-1:0] one_ld;
  logic          prod_last;

  // Inverter: remainder/coefficient pairs (a,x),(b,y) with a = x*e mod phi; shift-subtract division
  always_comb begin
    inv_state_d = inv_state_q;
    n_d   = n_q;
    phi_d = phi_q;
    a_d   = a_q;
    b_d   = b_q;
    x_d   = x_q;
    y_d   = y_q;
    k_d   = k_q;
    d_d   = d_q;
    case (inv_state_q)
      INV_LOAD: begin
        n_d   = XW'(p) * XW'(q);
        phi_d = XW'(p - WIDTH'(1)) * XW'(q - WIDTH'(1));
        a_d   = phi_d;
        b_d   = E_PUB;
        x_d   = '0;
        y_d   = MW'(1);
        inv_state_d = INV_CHECK;
      end
      INV_CHECK: begin
        k_d = CW'(XW - 1);
        inv_state_d = (b_q == '0) ? INV_FIN : INV_DIV;
      end
      INV_DIV: begin
        if ((a_q >> k_q) >= b_q) begin
          a_d = a_q - (b_q << k_q);
          x_d = x_q - (y_q <<< k_q);
        end
        if (k_q == '0) inv_state_d = INV_SWAP;
        else           k_d = k_q - CW'(1);
      end
      INV_SWAP: begin
        a_d = b_q;
        b_d = a_q;
        x_d = y_q;
        y_d = x_q;
        inv_state_d = INV_CHECK;
      end
      INV_FIN: begin
        // gcd lands in a; a non-unit gcd means e has no inverse
        d_d = (a_q == XW'(1)) ? XW'(x_q[MW-1] ? (x_q + $signed(MW'(phi_q))) : x_q) : '0;
        inv_state_d = INV_DONE;
      end
      INV_DONE: inv_state_d = INV_DONE;
      default:  inv_state_d = INV_LOAD;
    endcase
    inv_done_d = (inv_state_d == INV_DONE);
  end

  always_ff @(posedge clk or posedge reset_inverter) begin
    if (reset_inverter) begin
      inv_state_q <= INV_LOAD;
      inv_done_q  <= 1'b0;
    end else begin
      inv_state_q <= inv_state_d;
      inv_done_q  <= inv_done_d;
    end
  end

  always_ff @(posedge clk) begin
    n_q   <= n_d;
    phi_q <= phi_d;
    a_q   <= a_d;
    b_q   <= b_d;
    x_q   <= x_d;
    y_q   <= y_d;
    k_q   <= k_d;
    d_q   <= d_d;
  end

  // Interleaved modular product step: acc = 2*acc (+ mb if multiplier msb) mod n
  always_comb begin
    dbl       = MW'({acc_q, 1'b0});
    dbl_r     = (dbl >= MW'(mn_q)) ? dbl - MW'(mn_q) : dbl;
    sum       = dbl_r + (ma_q[XW-1] ? MW'(mb_q) : '0);
    step      = (sum >= MW'(mn_q)) ? sum - MW'(mn_q) : sum;
    prod_last = (cnt_q == CW'(XW - 1));
    one_ld    = (n_q == XW'(1)) ? '0 : XW'(1);
  end

  always_comb begin
    me_state_d = me_state_q;
    msg_out_d  = msg_out_q;
    mn_d   = mn_q;
    exp_d  = exp_q;
    base_d = base_q;
    res_d  = res_q;
    acc_d  = acc_q;
    mb_d   = mb_q;
    ma_d   = ma_q;
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    case (me_state_q)
      ME_LOAD: begin
        mn_d  = n_q;
        exp_d = encrypt_decrypt ? d_q : E_PUB;
        res_d = one_ld;
        mb_d  = one_ld;
        ma_d  = msg_in;
        acc_d = '0;
        cnt_d = '0;
        bit_d = '0;
        me_state_d = ME_REDUCE;
      end
      ME_REDUCE, ME_SQUARE, ME_MULT: begin
        acc_d = XW'(step);
        ma_d  = ma_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (prod_last) begin
          acc_d = '0;
          cnt_d = '0;
          if (me_state_q == ME_REDUCE) begin
            // base = msg_in * 1 mod n folds oversized messages below n
            base_d = XW'(step);
            mb_d   = res_q;
            ma_d   = res_q;
            me_state_d = ME_SQUARE;
          end else if (me_state_q == ME_SQUARE) begin
            res_d = XW'(step);
            if (exp_q[XW-1]) begin
              mb_d = base_q;
              ma_d = XW'(step);
              me_state_d = ME_MULT;
            end else begin
              me_state_d = ME_NEXT;
            end
          end else begin
            res_d = XW'(step);
            me_state_d = ME_NEXT;
          end
        end
      end
      ME_NEXT: begin
        exp_d = exp_q << 1;
        if (bit_q == CW'(XW - 1)) begin
          msg_out_d  = res_q;
          me_state_d = ME_DONE;
        end else begin
          bit_d = bit_q + CW'(1);
          mb_d  = res_q;
          ma_d  = res_q;
          acc_d = '0;
          cnt_d = '0;
          me_state_d = ME_SQUARE;
        end
      end
      ME_DONE: me_state_d = ME_DONE;
      default: me_state_d = ME_LOAD;
    endcase
    me_done_d = (me_state_d == ME_DONE);
  end

  always_ff @(posedge clk or posedge reset_mod_exp) begin
    if (reset_mod_exp) begin
      me_state_q <= ME_LOAD;
      me_done_q  <= 1'b0;
      msg_out_q  <= '0;
    end else begin
      me_state_q <= me_state_d;
      me_done_q  <= me_done_d;
      msg_out_q  <= msg_out_d;
    end
  end

  always_ff @(posedge clk) begin
    mn_q   <= mn_d;
    exp_q  <= exp_d;
    base_q <= base_d;
    res_q  <= res_d;
    acc_q  <= acc_d;
    mb_q   <= mb_d;
    ma_q   <= ma_d;
    cnt_q  <= cnt_d;
    bit_q  <= bit_d;
  end

  assign inverter_finish = inv_done_q;
  assign mod_exp_finish  = me_done_q;
  assign msg_out         = msg_out_q;

endmodule

// File: tb/tb_rsa_control.sv
// Bench for rsa_control at WIDTH=16: encrypt/decrypt instance pair checked
// against a plain-arithmetic RSA model (extended Euclid + modular power).
module tb_rsa_control;

  localparam int unsigned W  = 16;
  localparam int unsigned XW = 2 * W;
  localparam longint unsigned E_PUB = 65537;
  localparam int unsigned INV_LIM = 16 * W * W;
  localparam int unsigned ME_LIM  = 4 * XW * XW + 8 * W;

  logic          clk = 1'b0;
  logic [W-1:0]  p, q;
  logic          rst_inv;
  logic          rst_me_enc, rst_me_dec, ed_enc, ed_dec;
  logic [XW-1:0] msg_enc, msg_dec, out_enc, out_dec;
  logic          inv_fin_enc, inv_fin_dec, me_fin_enc, me_fin_dec;

  int checks = 0;
  int errors = 0;
  longint unsigned m_n, m_phi, m_d;
  logic [XW-1:0] r1, r2;
  longint unsigned mv;

  always #5 clk = ~clk;

  rsa_control #(.WIDTH(W)) u_enc (
    .clk(clk), .reset_inverter(rst_inv), .reset_mod_exp(rst_me_enc),
    .p(p), .q(q), .encrypt_decrypt(ed_enc), .msg_in(msg_enc),
    .inverter_finish(inv_fin_enc), .msg_out(out_enc), .mod_exp_finish(me_fin_enc)
  );

  rsa_control #(.WIDTH(W)) u_dec (
    .clk(clk), .reset_inverter(rst_inv), .reset_mod_exp(rst_me_dec),
    .p(p), .q(q), .encrypt_decrypt(ed_dec), .msg_in(msg_dec),
    .inverter_finish(inv_fin_dec), .msg_out(out_dec), .mod_exp_finish(me_fin_dec)
  );

  function automatic longint unsigned m_modpow(longint unsigned b, longint unsigned ex,
                                               longint unsigned n);
    longint unsigned r, bb, ee;
    if (n == 0) return 0;
    r = 1 % n;
    bb = b % n;
    ee = ex;
    while (ee != 0) begin
      if ((ee & 1) != 0) r = (r * bb) % n;
      bb = (bb * bb) % n;
      ee = ee >> 1;
    end
    return r;
  endfunction

  function automatic longint unsigned m_inv(longint unsigned phi);
    longint r0, r1x, t0, t1, qt, tmp;
    r0 = longint'(phi);
    r1x = longint'(E_PUB);
    t0 = 0;
    t1 = 1;
    while (r1x != 0) begin
      qt = r0 / r1x;
      tmp = r0 - qt * r1x;  r0 = r1x; r1x = tmp;
      tmp = t0 - qt * t1;   t0 = t1;  t1 = tmp;
    end
    if (r0 != 1) return 0;
    if (t0 < 0) t0 = t0 + longint'(phi);
    return $unsigned(t0) % phi;
  endfunction

  function automatic bit is_prime(int v);
    if (v < 2) return 1'b0;
    for (int i = 2; i * i <= v; i++)
      if (v % i == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [W-1:0] rand_prime();
    int v;
    do v = int'($urandom_range(300, 65521)); while (!is_prime(v));
    return W'(v);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse reset_inverter with pp/qq, scramble p/q afterwards, wait for both inverters
  task automatic keygen(input logic [W-1:0] pp, input logic [W-1:0] qq);
    int cyc;
    @(negedge clk);
    p = pp;
    q = qq;
    rst_inv = 1'b1;
    m_n   = 64'(pp) * 64'(qq);
    m_phi = (64'(pp) - 1) * (64'(qq) - 1);
    m_d   = m_inv(m_phi);
    repeat (2) @(negedge clk);
    chk("inv_fin_in_reset", 64'(inv_fin_enc), 64'd0);
    rst_inv = 1'b0;
    @(negedge clk);
    p = W'($urandom);
    q = W'($urandom);
    cyc = 0;
    while ((inv_fin_enc !== 1'b1 || inv_fin_dec !== 1'b1) && cyc < int'(INV_LIM)) begin
      @(negedge clk);
      cyc++;
    end
    chk("inv_fin", 64'(inv_fin_enc & inv_fin_dec), 64'd1);
    chk("n", 64'(u_enc.n_q), m_n);
    chk("phi", 64'(u_enc.phi_q), m_phi);
    chk("d_enc", 64'(u_enc.d_q), m_d);
    chk("d_dec", 64'(u_dec.d_q), m_d);
  endtask

  // Run one exponentiation on instance sel (0=u_enc, 1=u_dec)
  task automatic run_me(input bit sel, input logic ed, input logic [XW-1:0] m,
                        output logic [XW-1:0] res);
    int cyc;
    @(negedge clk);
    if (sel) begin rst_me_dec = 1'b1; ed_dec = ed; msg_dec = m; end
    else     begin rst_me_enc = 1'b1; ed_enc = ed; msg_enc = m; end
    repeat (2) @(negedge clk);
    chk("me_fin_in_reset", 64'(sel ? me_fin_dec : me_fin_enc), 64'd0);
    chk("msg_out_in_reset", 64'(sel ? out_dec : out_enc), 64'd0);
    if (sel) rst_me_dec = 1'b0; else rst_me_enc = 1'b0;
    @(negedge clk);
    if (sel) begin msg_dec = $urandom; ed_dec = ~ed; end
    else     begin msg_enc = $urandom; ed_enc = ~ed; end
    cyc = 0;
    while ((sel ? me_fin_dec : me_fin_enc) !== 1'b1 && cyc < int'(ME_LIM)) begin
      @(negedge clk);
      cyc++;
    end
    chk("me_fin", 64'(sel ? me_fin_dec : me_fin_enc), 64'd1);
    res = sel ? out_dec : out_enc;
  endtask

  initial begin
    p = '0; q = '0;
    rst_inv = 1'b1; rst_me_enc = 1'b1; rst_me_dec = 1'b1;
    ed_enc = 1'b0; ed_dec = 1'b1; msg_enc = '0; msg_dec = '0;
    repeat (3) @(negedge clk);
    chk("rst_inv_fin", 64'(inv_fin_enc), 64'd0);
    chk("rst_me_fin", 64'(me_fin_enc), 64'd0);
    chk("rst_msg_out", 64'(out_enc), 64'd0);
    rst_me_enc = 1'b0; rst_me_dec = 1'b0;

    // Textbook key: n=3233 phi=3120 d=2753
    keygen(16'd61, 16'd53);
    chk("n_3233", 64'(u_enc.n_q), 64'd3233);
    chk("d_2753", 64'(u_enc.d_q), 64'd2753);
    run_me(1'b0, 1'b0, 32'd65, r1);
    chk("enc_65", 64'(r1), 64'd2790);
    run_me(1'b1, 1'b1, r1, r2);
    chk("dec_2790", 64'(r2), 64'd65);

    run_me(1'b0, 1'b0, 32'd0, r1);
    chk("enc_zero", 64'(r1), 64'd0);
    run_me(1'b1, 1'b1, 32'd1, r2);
    chk("dec_one", 64'(r2), 64'd1);
    run_me(1'b0, 1'b0, 32'(m_n - 1), r1);
    chk("enc_nm1", 64'(r1), m_modpow(m_n - 1, E_PUB, m_n));
    run_me(1'b1, 1'b1, r1, r2);
    chk("trip_nm1", 64'(r2), m_n - 1);
    run_me(1'b0, 1'b0, 32'hFFFF_FFF0, r1);
    chk("enc_big_msg", 64'(r1), m_modpow(64'h0000_0000_FFFF_FFF0, E_PUB, m_n));

    // Restarting the inverter must leave finished exponentiation results alone
    @(negedge clk);
    rst_inv = 1'b1;
    repeat (2) @(negedge clk);
    chk("hold_inv_fin", 64'(inv_fin_dec), 64'd0);
    chk("hold_me_fin", 64'(me_fin_dec), 64'd1);
    chk("hold_msg_out", 64'(out_dec), m_n - 1);
    rst_inv = 1'b0;

    // Mid-cycle abort drops outputs without waiting for a clock edge
    keygen(16'd61, 16'd53);
    run_me(1'b0, 1'b0, 32'd65, r1);
    chk("pre_abort", 64'(r1), 64'd2790);
    @(negedge clk);
    #2 rst_me_enc = 1'b1;
    #1;
    chk("abort_fin", 64'(me_fin_enc), 64'd0);
    chk("abort_msg", 64'(out_enc), 64'd0);
    msg_enc = 32'd123;
    repeat (2) @(negedge clk);
    rst_me_enc = 1'b0;
    repeat (300) @(negedge clk);
    #2 rst_me_enc = 1'b1;
    #1;
    chk("abort_mid_fin", 64'(me_fin_enc), 64'd0);
    chk("abort_mid_msg", 64'(out_enc), 64'd0);
    run_me(1'b0, 1'b0, 32'd777, r1);
    chk("enc_after_abort", 64'(r1), m_modpow(777, E_PUB, m_n));

    // Random primes and messages, chained round trip
    for (int it = 0; it < 3; it++) begin
      keygen(rand_prime(), rand_prime());
      mv = 64'($urandom) % m_n;
      run_me(1'b0, 1'b0, 32'(mv), r1);
      chk("rnd_enc", 64'(r1), m_modpow(mv, E_PUB, m_n));
      run_me(1'b1, 1'b1, r1, r2);
      chk("rnd_trip", 64'(r2), mv);
    end

    // phi=0: no inverse, d=0, so decryption is exponent 0 -> 1 mod n
    keygen(16'd1, 16'd53);
    chk("d_noinv", 64'(u_dec.d_q), 64'd0);
    run_me(1'b1, 1'b1, 32'd7, r2);
    chk("dec_exp0", 64'(r2), 64'd1);

    // n=1 reduces everything to 0
    keygen(16'd1, 16'd1);
    run_me(1'b0, 1'b0, 32'd5, r1);
    chk("enc_n1", 64'(r1), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsa_control.md
Name: rsa_control

Overview:
- RSA engine: from primes p and q, forms modulus n = p·q and totient phi = (p-1)(q-1).
- Inverter phase computes private exponent d = e⁻¹ mod phi, with fixed public exponent e = 65537.
- Modular-exponentiation phase produces msg_out = msg_in^e mod n (encrypt) or msg_in^d mod n (decrypt).
- Two instances chained (encrypt then decrypt, same p/q) must return the original message.

Parameters:
- WIDTH, 128, bit width of each prime; modulus, messages and exponents are 2*WIDTH bits.

Ports:
- p  in  WIDTH  first prime.
- q  in  WIDTH  second prime.
- clk  in  1  single clock, all state on rising edge.
- reset_inverter  in  1  asynchronous active-high reset/start of inverter phase.
- reset_mod_exp  in  1  asynchronous active-high reset/start of exponentiation phase.
- encrypt_decrypt  in  1  0 = encrypt (exponent e), 1 = decrypt (exponent d).
- msg_in  in  2*WIDTH  input message, < n.
- inverter_finish  out  1  high when n, phi and d are valid.
- msg_out  out  2*WIDTH  result.
- mod_exp_finish  out  1  high when msg_out is valid.

Behaviour:
- Both resets are asynchronous, active-high; the two phases are independent state machines.
- While reset_inverter is high:
  - inverter_finish = 0.
  - p and q are loaded continuously.
  - n and phi are computed; full product, no truncation, 2*WIDTH bits.
  - Extended-Euclid registers are initialised.
- Inverter FSM: IDLE/LOAD -> MULT (if the product is iterative) -> EUCLID -> DONE.
  - Computation starts on the first clk edge after reset_inverter falls.
  - Binary or division-based extended Euclid on (phi, e).
  - d is normalised to 0..phi-1.
  - DONE: inverter_finish = 1, held until the next reset_inverter.
  - If gcd(e, phi) != 1, d = 0 and DONE is still reached.
  - Bound: inverter_finish within 16*WIDTH² cycles.
- While reset_mod_exp is high:
  - mod_exp_finish = 0 and msg_out = 0.
  - msg_in and encrypt_decrypt are loaded continuously.
  - The exponent is selected (e or the current d); the accumulator is set to 1 mod n.
- Exponent FSM: IDLE -> SQUARE -> MULTIPLY -> NEXT_BIT -> DONE.
  - Left-to-right square-and-multiply over 2*WIDTH exponent bits.
  - Each modular product uses interleaved shift-add reduction, one multiplier bit per cycle.
  - Intermediates are kept < n in a (2*WIDTH+2)-bit accumulator; no full 4*WIDTH multiplier.
  - DONE: msg_out = result, mod_exp_finish = 1, both held until the next reset_mod_exp.
  - Bound: done within 4*(2*WIDTH)² + 8*WIDTH cycles.
- The exponentiation phase is only valid after inverter_finish = 1.
  - Asserting reset_mod_exp earlier still runs, using the current (possibly stale) n and d.
- Boundary cases:
  - Exponent 0 gives 1 mod n.
  - n = 1 gives 0.
  - msg_in >= n: the result is (msg_in mod n)^exp mod n.
  - msg_in = 0 gives 0; msg_in = 1 gives 1.
- Reset mid-operation: either reset aborts its phase immediately, clears its finish flag (and msg_out for reset_mod_exp), then restarts. The other phase is untouched.
- Inputs p, q, msg_in and encrypt_decrypt may change after their reset falls without affecting the running computation.

Test Plan:
- WIDTH=16, p=61, q=53, pulse reset_inverter -> inverter_finish rises; internal n=3233, phi=3120, d=2753.
- Same setup, encrypt_decrypt=0, msg_in=65, pulse reset_mod_exp -> mod_exp_finish=1, msg_out=2790.
- Second instance, same p/q, encrypt_decrypt=1, msg_in=2790 -> msg_out=65; chained round-trip is identity.
- WIDTH=128, p=113680897410347, q=7999808077935876437321, msg_in=0xf03a00000000000000:
  - encrypt, feed msg_out into a decrypt instance -> decrypt msg_out equals msg_in.
  - Repeat with p/q swapped and msg_in=0xb37b2857e7e100.
- Edge cases: msg_in=0 -> 0; msg_in=1 -> 1; msg_in=n-1 -> encrypt then decrypt returns n-1.
- Assert reset_mod_exp mid-computation -> mod_exp_finish and msg_out drop to 0 asynchronously; the restarted run yields the correct value.
